// File: rtl/mem_loader_pkg.sv
// Shared types and default constants for the mem_loader_seq host sequencer.
package mem_loader_pkg;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_I_WAIT = 4'd1,
      S_I_WR   = 4'd2,
      S_I_GAP  = 4'd3,
      S_GAP1   = 4'd4,
      S_D_WAIT = 4'd5,
      S_D_WR   = 4'd6,
      S_D_GAP  = 4'd7,
      S_GAP2   = 4'd8,
      S_RUN    = 4'd9,
      S_GAP3   = 4'd10,
      S_RB_RD  = 4'd11,
      S_RB_OUT = 4'd12,
      S_FIN    = 4'd13
   } state_t;

   localparam int DEF_ADDR_W     = 9;
   localparam int DEF_DATA_W     = 16;
   localparam int DEF_LOAD_BASE  = 1;
   localparam int DEF_WR_HOLD    = 4;
   localparam int DEF_RD_WAIT    = 5;
   localparam int DEF_RUN_CYCLES = 120000;
   localparam int DEF_RB_BASE    = 91;
   localparam int DEF_RB_LEN     = 10;

   // Sizes the shared strobe timer to the longest of the three timed phases.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/mem_loader_seq_strobe_timer.sv
// strobe_timer: loadable down-counter; o_tc is high while the count sits at zero.
module mem_loader_seq_strobe_timer
   import mem_loader_pkg::*;
#(
   parameter int CNT_W = $clog2(DEF_RUN_CYCLES + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_value,
   output logic             o_tc
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_value;
      end else if (r_count != '0) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_tc = (r_count == '0);

endmodule

// File: rtl/mem_loader_seq.sv
// Host-side load / run / readback sequencer for top_control.
// Optional checksum output enabled by defining MEM_LOADER_CHECKSUM_EN.
module mem_loader_seq
   import mem_loader_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int LOAD_BASE  = DEF_LOAD_BASE,
   parameter int WR_HOLD    = DEF_WR_HOLD,
   parameter int RD_WAIT    = DEF_RD_WAIT,
   parameter int RUN_CYCLES = DEF_RUN_CYCLES,
   parameter int RB_BASE    = DEF_RB_BASE,
   parameter int RB_LEN     = DEF_RB_LEN
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              go,
   input  logic [ADDR_W-1:0] ins_len,
   input  logic [ADDR_W-1:0] dat_len,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done,
   output logic              start,
   output logic              start_2,
   output logic              start_3,
   output logic              start_4,
   output logic [ADDR_W-1:0] addr_ext,
   output logic              iram_write_ext,
   output logic              dram_write_ext,
   output logic              read_en_ext,
   output logic [DATA_W-1:0] Data_in_ins,
   output logic [DATA_W-1:0] Data_in_dram,
   input  logic [DATA_W-1:0] dram_in
`ifdef MEM_LOADER_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0] csum
`endif
);

   localparam int TMR_W = $clog2(max3(WR_HOLD, RD_WAIT, RUN_CYCLES) + 1);

   state_t            r_state;
   logic [ADDR_W-1:0] r_ins_len;
   logic [ADDR_W-1:0] r_dat_len;
   logic [ADDR_W-1:0] r_count;
   logic [ADDR_W-1:0] r_addr;
   logic              r_in_ready;
   logic [DATA_W-1:0] r_out_data;
   logic              r_out_valid;
   logic              r_busy;
   logic              r_done;
   logic              r_start;
   logic              r_start_2;
   logic              r_start_3;
   logic              r_start_4;
   logic              r_iram_we;
   logic              r_dram_we;
   logic              r_rd_en;
   logic [DATA_W-1:0] r_din_ins;
   logic [DATA_W-1:0] r_din_dram;
`ifdef MEM_LOADER_CHECKSUM_EN
   logic [DATA_W-1:0] r_csum;
`endif

   logic              w_in_hs;
   logic              w_out_hs;
   logic [ADDR_W-1:0] w_count_inc;
   logic              w_last_rb;
   logic              w_tmr_load;
   logic [TMR_W-1:0]  w_tmr_value;
   logic              w_tmr_tc;

   assign w_in_hs     = in_valid & r_in_ready;
   assign w_out_hs    = r_out_valid & out_ready;
   assign w_count_inc = r_count + 1'b1;
   assign w_last_rb   = (w_count_inc == ADDR_W'(RB_LEN));

   // Timer is loaded with N-1 on the transition into a timed state, so its
   // terminal count lands on the N-th cycle of that state.
   always_comb begin
      w_tmr_load  = 1'b0;
      w_tmr_value = TMR_W'(WR_HOLD - 1);
      case (r_state)
         S_I_WAIT, S_D_WAIT: begin
            w_tmr_load = w_in_hs;
         end
         S_GAP2: begin
            w_tmr_load  = 1'b1;
            w_tmr_value = TMR_W'(RUN_CYCLES - 1);
         end
         S_GAP3: begin
            w_tmr_load  = 1'b1;
            w_tmr_value = TMR_W'(RD_WAIT - 1);
         end
         S_RB_OUT: begin
            w_tmr_load  = w_out_hs & ~w_last_rb;
            w_tmr_value = TMR_W'(RD_WAIT - 1);
         end
         default: begin
            w_tmr_load = 1'b0;
         end
      endcase
   end

   mem_loader_seq_strobe_timer #(
      .CNT_W (TMR_W)
   ) u_timer (
      .i_clk   (clock),
      .i_rst   (reset),
      .i_load  (w_tmr_load),
      .i_value (w_tmr_value),
      .o_tc    (w_tmr_tc)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_ins_len   <= '0;
         r_dat_len   <= '0;
         r_count     <= '0;
         r_addr      <= '0;
         r_in_ready  <= 1'b0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_start     <= 1'b0;
         r_start_2   <= 1'b0;
         r_start_3   <= 1'b0;
         r_start_4   <= 1'b0;
         r_iram_we   <= 1'b0;
         r_dram_we   <= 1'b0;
         r_rd_en     <= 1'b0;
         r_din_ins   <= '0;
         r_din_dram  <= '0;
`ifdef MEM_LOADER_CHECKSUM_EN
         r_csum      <= '0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (go) begin
                  r_ins_len <= ins_len;
                  r_dat_len <= dat_len;
                  r_count   <= '0;
                  r_addr    <= ADDR_W'(LOAD_BASE);
                  r_busy    <= 1'b1;
`ifdef MEM_LOADER_CHECKSUM_EN
                  r_csum    <= '0;
`endif
                  if (ins_len == '0) begin
                     r_state <= S_GAP1;
                  end else begin
                     r_start_2  <= 1'b1;
                     r_in_ready <= 1'b1;
                     r_state    <= S_I_WAIT;
                  end
               end
            end
            S_I_WAIT: begin
               if (w_in_hs) begin
                  r_din_ins  <= in_data;
                  r_in_ready <= 1'b0;
                  r_iram_we  <= 1'b1;
                  r_state    <= S_I_WR;
               end
            end
            S_I_WR: begin
               if (w_tmr_tc) begin
                  r_iram_we <= 1'b0;
                  r_addr    <= r_addr + 1'b1;
                  r_count   <= w_count_inc;
                  r_state   <= S_I_GAP;
               end
            end
            S_I_GAP: begin
               if (r_count == r_ins_len) begin
                  r_start_2 <= 1'b0;
                  r_state   <= S_GAP1;
               end else begin
                  r_in_ready <= 1'b1;
                  r_state    <= S_I_WAIT;
               end
            end
            S_GAP1: begin
               r_count <= '0;
               r_addr  <= ADDR_W'(LOAD_BASE);
               if (r_dat_len == '0) begin
                  r_state <= S_GAP2;
               end else begin
                  r_start_3  <= 1'b1;
                  r_in_ready <= 1'b1;
                  r_state    <= S_D_WAIT;
               end
            end
            S_D_WAIT: begin
               if (w_in_hs) begin
                  r_din_dram <= in_data;
                  r_in_ready <= 1'b0;
                  r_dram_we  <= 1'b1;
                  r_state    <= S_D_WR;
               end
            end
            S_D_WR: begin
               if (w_tmr_tc) begin
                  r_dram_we <= 1'b0;
                  r_addr    <= r_addr + 1'b1;
                  r_count   <= w_count_inc;
                  r_state   <= S_D_GAP;
               end
            end
            S_D_GAP: begin
               if (r_count == r_dat_len) begin
                  r_start_3 <= 1'b0;
                  r_state   <= S_GAP2;
               end else begin
                  r_in_ready <= 1'b1;
                  r_state    <= S_D_WAIT;
               end
            end
            S_GAP2: begin
               r_start <= 1'b1;
               r_state <= S_RUN;
            end
            S_RUN: begin
               if (w_tmr_tc) begin
                  r_start <= 1'b0;
                  r_state <= S_GAP3;
               end
            end
            S_GAP3: begin
               r_start_4 <= 1'b1;
               r_addr    <= ADDR_W'(RB_BASE);
               r_count   <= '0;
               r_rd_en   <= 1'b1;
               r_state   <= S_RB_RD;
            end
            S_RB_RD: begin
               if (w_tmr_tc) begin
                  r_out_data  <= dram_in;
                  r_rd_en     <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_state     <= S_RB_OUT;
               end
            end
            S_RB_OUT: begin
               if (w_out_hs) begin
                  r_out_valid <= 1'b0;
                  r_addr      <= r_addr + 1'b1;
                  r_count     <= w_count_inc;
`ifdef MEM_LOADER_CHECKSUM_EN
                  r_csum      <= r_csum + r_out_data;
`endif
                  if (w_last_rb) begin
                     r_start_4 <= 1'b0;
                     r_done    <= 1'b1;
                     r_state   <= S_FIN;
                  end else begin
                     r_rd_en <= 1'b1;
                     r_state <= S_RB_RD;
                  end
               end
            end
            S_FIN: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready       = r_in_ready;
   assign out_data       = r_out_data;
   assign out_valid      = r_out_valid;
   assign busy           = r_busy;
   assign done           = r_done;
   assign start          = r_start;
   assign start_2        = r_start_2;
   assign start_3        = r_start_3;
   assign start_4        = r_start_4;
   assign addr_ext       = r_addr;
   assign iram_write_ext = r_iram_we;
   assign dram_write_ext = r_dram_we;
   assign read_en_ext    = r_rd_en;
   assign Data_in_ins    = r_din_ins;
   assign Data_in_dram   = r_din_dram;
`ifdef MEM_LOADER_CHECKSUM_EN
   assign csum           = r_csum;
`endif

endmodule

// File: tb/tb_mem_loader_seq.sv
// Directed bench for mem_loader_seq: reset abort, load/run/readback, go-while-busy, empty load.
module tb_mem_loader_seq;

   localparam int ADDR_W = 9;
   localparam int DATA_W = 16;
   localparam int RUN_T  = 20;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              go = 1'b0;
   logic [ADDR_W-1:0] ins_len = '0;
   logic [ADDR_W-1:0] dat_len = '0;
   logic [DATA_W-1:0] in_data = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic              busy, done, start, start_2, start_3, start_4;
   logic [ADDR_W-1:0] addr_ext;
   logic              iram_write_ext, dram_write_ext, read_en_ext;
   logic [DATA_W-1:0] Data_in_ins, Data_in_dram;
   logic [DATA_W-1:0] dram_in;
`ifdef MEM_LOADER_CHECKSUM_EN
   logic [DATA_W-1:0] csum;
`endif

   always #5 clock = ~clock;

   // DRAM model: every address reads back as twice its value.
   assign dram_in = {6'b0, addr_ext, 1'b0};

   mem_loader_seq #(.RUN_CYCLES(RUN_T)) dut (
      .clock          (clock),
      .reset          (reset),
      .go             (go),
      .ins_len        (ins_len),
      .dat_len        (dat_len),
      .in_data        (in_data),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .out_data       (out_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .busy           (busy),
      .done           (done),
      .start          (start),
      .start_2        (start_2),
      .start_3        (start_3),
      .start_4        (start_4),
      .addr_ext       (addr_ext),
      .iram_write_ext (iram_write_ext),
      .dram_write_ext (dram_write_ext),
      .read_en_ext    (read_en_ext),
      .Data_in_ins    (Data_in_ins),
      .Data_in_dram   (Data_in_dram),
      .dram_in        (dram_in)
`ifdef MEM_LOADER_CHECKSUM_EN
      ,
      .csum           (csum)
`endif
   );

   int total = 0;
   int bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Write-strobe, run-window, done and exclusivity monitor (samples 2ns after each rising edge).
   logic [ADDR_W-1:0] iw_a [0:15];
   logic [DATA_W-1:0] iw_d [0:15];
   int                iw_l [0:15];
   logic [ADDR_W-1:0] dw_a [0:15];
   logic [DATA_W-1:0] dw_d [0:15];
   int                dw_l [0:15];
   int iw_n = 0, iw_run = 0, dw_n = 0, dw_run = 0, unstable = 0;
   int st_run = 0, st_len = 0, done_n = 0, excl_err = 0;

   always @(posedge clock) begin
      #2;
      if (iram_write_ext) begin
         if (iw_run == 0 && iw_n < 16) begin
            iw_a[iw_n] = addr_ext;
            iw_d[iw_n] = Data_in_ins;
         end else if (iw_n < 16 && (addr_ext !== iw_a[iw_n] || Data_in_ins !== iw_d[iw_n])) begin
            unstable++;
         end
         iw_run++;
      end else if (iw_run != 0) begin
         if (iw_n < 16) iw_l[iw_n] = iw_run;
         $display("iram write: addr=%0d data=%0d cycles=%0d", iw_a[iw_n], iw_d[iw_n], iw_run);
         iw_n++;
         iw_run = 0;
      end
      if (dram_write_ext) begin
         if (dw_run == 0 && dw_n < 16) begin
            dw_a[dw_n] = addr_ext;
            dw_d[dw_n] = Data_in_dram;
         end else if (dw_n < 16 && (addr_ext !== dw_a[dw_n] || Data_in_dram !== dw_d[dw_n])) begin
            unstable++;
         end
         dw_run++;
      end else if (dw_run != 0) begin
         if (dw_n < 16) dw_l[dw_n] = dw_run;
         $display("dram write: addr=%0d data=%0d cycles=%0d", dw_a[dw_n], dw_d[dw_n], dw_run);
         dw_n++;
         dw_run = 0;
      end
      if (start) st_run++;
      else if (st_run != 0) begin
         st_len = st_run;
         st_run = 0;
      end
      if (done) done_n++;
      if ((int'(start) + int'(start_2) + int'(start_3) + int'(start_4)) > 1 ||
          (iram_write_ext && !start_2) || (dram_write_ext && !start_3) ||
          (read_en_ext && !start_4) || (in_ready && !(start_2 || start_3)))
         excl_err++;
   end

   logic [DATA_W-1:0] words [0:5];
   int idx, cyc, pend, chg, iw_base, dw_base, d0;

   initial begin
      words[0] = 16'd10; words[1] = 16'd20; words[2] = 16'd30;
      words[3] = 16'd40; words[4] = 16'd50; words[5] = 16'd99;

      // Reset state
      repeat (3) @(negedge clock);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_addr", addr_ext, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_selects", {start, start_2, start_3, start_4}, 0);
      chk("rst_strobes", {iram_write_ext, dram_write_ext, read_en_ext, out_valid}, 0);
      reset = 1'b0;
      @(negedge clock);

      // Reset in the second cycle of an IRAM write strobe
      ins_len = 9'd2; dat_len = 9'd0; in_data = 16'd77; in_valid = 1'b1; go = 1'b1;
      @(negedge clock); go = 1'b0;
      chk("ab_addr_load", addr_ext, 1);
      @(negedge clock);
      chk("ab_iram_on", iram_write_ext, 1);
      @(negedge clock);
      reset = 1'b1;
      #1;
      chk("ab_iram_async", iram_write_ext, 0);
      chk("ab_start2_async", start_2, 0);
      chk("ab_addr_async", addr_ext, 0);
      in_valid = 1'b0;
      @(negedge clock); reset = 1'b0;
      repeat (2) @(negedge clock);
      iw_base = iw_n; dw_base = dw_n; d0 = done_n;

      // Full load: ins_len=3, dat_len=2, words 10..50, in_valid held high
      ins_len = 9'd3; dat_len = 9'd2; idx = 0; in_data = words[0]; in_valid = 1'b1; go = 1'b1;
      pend = 0; cyc = 0;
      while (!start && cyc < 500) begin
         @(negedge clock); go = 1'b0; cyc++;
         if (pend != 0) begin
            if (idx < 5) idx++;
            in_data = words[idx];
            pend = 0;
         end
         if (in_ready) pend = 1;
      end
      chk("ld_reached_run", start, 1);
      chk("ld_iram_count", iw_n - iw_base, 3);
      chk("ld_dram_count", dw_n - dw_base, 2);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("iw%0d_addr", i), iw_a[iw_base+i], i + 1);
         chk($sformatf("iw%0d_data", i), iw_d[iw_base+i], 10 * (i + 1));
         chk($sformatf("iw%0d_len", i), iw_l[iw_base+i], 4);
      end
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("dw%0d_addr", i), dw_a[dw_base+i], i + 1);
         chk($sformatf("dw%0d_data", i), dw_d[dw_base+i], 40 + 10 * i);
         chk($sformatf("dw%0d_len", i), dw_l[dw_base+i], 4);
      end
      chk("ld_stable", unstable, 0);

      // go while busy in RUN must be ignored
      go = 1'b1; ins_len = 9'd5;
      repeat (3) @(negedge clock);
      go = 1'b0;
      cyc = 0;
      while (start && cyc < 100) begin @(negedge clock); cyc++; end
      chk("run_ended", start, 0);
      chk("run_len", st_len, RUN_T);

      // Readback of 10 words, holding out_ready low 7 cycles on word 3
      for (int k = 0; k < 10; k++) begin
         cyc = 0;
         while (!out_valid && cyc < 100) begin @(negedge clock); cyc++; end
         chk($sformatf("rb%0d_valid", k), out_valid, 1);
         chk($sformatf("rb%0d_data", k), out_data, 182 + 2 * k);
         chk($sformatf("rb%0d_addr", k), addr_ext, 91 + k);
         if (k == 3) begin
            chg = 0;
            repeat (7) begin
               @(negedge clock);
               if (out_data !== 16'd188 || addr_ext !== 9'd94 || out_valid !== 1'b1) chg++;
            end
            chk("rb_hold_stable", chg, 0);
         end
         $display("readback word %0d: addr=%0d data=%0d", k, addr_ext, out_data);
         out_ready = 1'b1;
         @(negedge clock);
         out_ready = 1'b0;
      end
      chk("seq1_done_pulse", done, 1);
`ifdef MEM_LOADER_CHECKSUM_EN
      chk("seq1_csum", csum, 1910);
`endif
      @(negedge clock);
      chk("seq1_done_low", done, 0);
      chk("seq1_idle", busy, 0);
      repeat (5) @(negedge clock);
      chk("seq1_done_once", done_n - d0, 1);
      chk("seq1_still_idle", busy, 0);

      // Empty load: no strobes, just run and readback
      iw_base = iw_n; dw_base = dw_n; d0 = done_n;
      in_valid = 1'b1; ins_len = 9'd0; dat_len = 9'd0; go = 1'b1;
      @(negedge clock); go = 1'b0;
      chk("e_busy", busy, 1);
      chk("e_no_start2", start_2, 0);
      chk("e_no_ready", in_ready, 0);
      cyc = 0;
      while (!start && cyc < 50) begin @(negedge clock); cyc++; end
      chk("e_run_start", start, 1);
      cyc = 0;
      while (start && cyc < 100) begin @(negedge clock); cyc++; end
      chk("e_run_len", st_len, RUN_T);
      out_ready = 1'b1;
      cyc = 0;
      while (!done && cyc < 300) begin @(negedge clock); cyc++; end
      chk("e_done", done, 1);
      chk("e_last_word", out_data, 200);
`ifdef MEM_LOADER_CHECKSUM_EN
      chk("e_csum", csum, 1910);
`endif
      out_ready = 1'b0; in_valid = 1'b0;
      repeat (3) @(negedge clock);
      chk("e_no_iram", iw_n - iw_base, 0);
      chk("e_no_dram", dw_n - dw_base, 0);
      chk("e_done_once", done_n - d0, 1);
      chk("exclusivity", excl_err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_loader_seq.md
Name: mem_loader_seq

Overview:
- Host-side sequencer that sits directly upstream of top_control and drives its external load/readback ports.
- Accepts a 16-bit word stream over a valid/ready handshake and writes it into IRAM, then into DRAM.
- Then pulses the processor start for a fixed run window and streams a DRAM result window back out.
- Replaces the hand-timed testbench loading with synthesizable logic suitable for a UART/host bridge.

Parameters:
- ADDR_W, 9, width of addr_ext and length inputs
- DATA_W, 16, word width
- LOAD_BASE, 1, first IRAM/DRAM address written
- WR_HOLD, 4, cycles iram/dram_write_ext held high per word
- RD_WAIT, 5, cycles read_en_ext held high before dram_in sampled
- RUN_CYCLES, 120000, cycles start held high
- RB_BASE, 91, first DRAM readback address
- RB_LEN, 10, number of readback words

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- go  in  1  begin sequence (sampled in IDLE only)
- ins_len  in  ADDR_W  IRAM word count, latched on go
- dat_len  in  ADDR_W  DRAM word count, latched on go
- in_data  in  DATA_W  stream word
- in_valid  in  1  stream word valid
- in_ready  out  1  sequencer can accept word
- out_data  out  DATA_W  readback word
- out_valid  out  1  readback word valid
- out_ready  in  1  consumer accepts readback word
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at end of sequence
- start, start_2, start_3, start_4  out  1 each  processor run / IRAM load / DRAM load / readback mode selects
- addr_ext  out  ADDR_W  external memory address
- iram_write_ext, dram_write_ext, read_en_ext  out  1 each  external strobes
- Data_in_ins, Data_in_dram  out  DATA_W  external write data
- dram_in  in  DATA_W  DRAM read data from top_control

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-operation aborts immediately; no partial write is completed.
- States: IDLE -> I_WAIT -> I_WR -> I_GAP -> GAP1 -> D_WAIT -> D_WR -> D_GAP -> GAP2 -> RUN -> GAP3 -> RB_RD -> RB_OUT -> FIN -> IDLE.
- IDLE:
  - On go, latch ins_len and dat_len, set addr_ext=LOAD_BASE and start_2=1.
  - Enter I_WAIT, or GAP1 if ins_len=0.
  - go is ignored while busy.
- I_WAIT:
  - in_ready=1.
  - On in_valid&in_ready, register Data_in_ins<=in_data and enter I_WR.
- I_WR: iram_write_ext=1 for exactly WR_HOLD cycles; addr and data stable throughout.
- I_GAP (1 cycle):
  - Strobe low; addr_ext+1, wrapping mod 2^ADDR_W; count+1.
  - If count==ins_len go to GAP1, else I_WAIT.
- GAP1 (1 cycle):
  - All mode selects low.
  - Next cycle start_3=1, addr_ext=LOAD_BASE.
- DRAM phase: D_WAIT / D_WR / D_GAP behave identically, using Data_in_dram and dram_write_ext, ending in GAP2. dat_len=0 skips directly to GAP2.
- Mode-select exclusivity: at most one of start, start_2, start_3, start_4 is high in any cycle; never high at the same time as a different phase's strobe.
- RUN: start=1 for exactly RUN_CYCLES cycles, then GAP3 (1 cycle, all low).
- Readback:
  - start_4=1 and addr_ext=RB_BASE.
  - RB_RD: read_en_ext=1 for RD_WAIT cycles; dram_in captured into out_data on the last cycle.
  - RB_OUT: read_en_ext=0, out_valid=1, out_data stable until out_ready. On acceptance, addr+1; after RB_LEN words go to FIN.
- FIN: done=1 for one cycle, mode selects low, return to IDLE.
- in_ready is 0 outside I_WAIT/D_WAIT. Stream words offered at other times are not consumed.
- Latency per load word: 1 accept + WR_HOLD + 1 gap = WR_HOLD+2 cycles minimum.

Optional Feature:
- Macro: MEM_LOADER_CHECKSUM_EN.
- When defined:
  - Extra output port csum (DATA_W) holds a modulo-2^DATA_W sum of every accepted readback word.
  - csum clears on go; valid when done pulses.
- When undefined: port and adder absent; all other behaviour identical.

Decomposition:
- Shared package mem_loader_pkg: state enum encoding, default WR_HOLD/RD_WAIT/RB_BASE/RB_LEN constants.
- One natural sub-module: strobe_timer (loadable down-counter with terminal-count flag), reused for WR_HOLD, RD_WAIT and RUN_CYCLES.

Test Plan:
- Reset during I_WR (2nd cycle):
  - Expected: iram_write_ext, start_2 and addr_ext drop to 0 asynchronously.
  - Expected: next go restarts at addr 1.
- go with ins_len=3, dat_len=2, words 10,20,30,40,50, in_valid always high:
  - Expected IRAM writes: 10@1, 20@2, 30@3, each strobe exactly 4 cycles.
  - Expected DRAM writes: 40@1, 50@2.
- ins_len=0, dat_len=0:
  - Expected: no write strobes; start high exactly RUN_CYCLES cycles (bench overrides to 20).
- Readback with RB_BASE=91, RB_LEN=10, dram_in=addr*2:
  - Expected: out_data 182..200 in order.
  - Hold out_ready low 7 cycles on word 3; expected: out_data stable, addr_ext unchanged.
- go asserted while busy in RUN:
  - Expected: ignored; exactly one done pulse at the end.
- MEM_LOADER_CHECKSUM_EN defined, same readback:
  - Expected: csum = 1910 when done pulses.
